// File: rtl/hazard_unit.sv
// Hazard unit: bypass select, load-use and mult/div interlock.
// Ports: clock/reset, iss_* decode info, flush; sel_a/sel_b, stall, md_busy/md_done/md_rd.
module hazard_unit #(
  parameter int DEPTH     = 2,
  parameter int RW        = 5,
  parameter int MD_CYCLES = 32,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic [RW-1:0] iss_rs1,
  input  logic [RW-1:0] iss_rs2,
  input  logic          iss_use1,
  input  logic          iss_use2,
  input  logic [RW-1:0] iss_rd,
  input  logic          iss_we,
  input  logic          iss_load,
  input  logic          iss_md,
  input  logic          flush,
  output logic [SW-1:0] sel_a,
  output logic [SW-1:0] sel_b,
  output logic          stall,
  output logic          md_busy,
  output logic          md_done,
  output logic [RW-1:0] md_rd
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  // Tracker, entry 1 is the youngest writer.
  logic [DEPTH:1] tv;
  logic [DEPTH:1] twe;
  logic [DEPTH:1] tld;
  logic [RW-1:0]  trd [1:DEPTH];

  logic [CW-1:0]  cnt;
  logic           load_use;
  logic           md_stall;
  logic           accept;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (tv[k] && twe[k] && trd[k] != '0) begin
        if (iss_use1 && trd[k] == iss_rs1) sel_a = SW'(k);
        if (iss_use2 && trd[k] == iss_rs2) sel_b = SW'(k);
      end
    end
  end

  assign md_busy = (cnt != '0);
  assign md_done = (cnt == CW'(1));

  always_comb begin
    load_use = tv[1] && twe[1] && tld[1] && trd[1] != '0 &&
               ((iss_use1 && trd[1] == iss_rs1) ||
                (iss_use2 && trd[1] == iss_rs2));
    // The done cycle frees the unit and its result.
    md_stall = md_busy && !md_done &&
               (iss_md ||
                (md_rd != '0 &&
                 ((iss_use1 && md_rd == iss_rs1) ||
                  (iss_use2 && md_rd == iss_rs2) ||
                  (iss_we && md_rd == iss_rd))));
    stall    = iss_valid && (load_use || md_stall);
    accept   = iss_valid && !stall && !flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tv  <= '0;
      twe <= '0;
      tld <= '0;
      for (int k = 1; k <= DEPTH; k++) trd[k] <= '0;
    end else begin
      tv[1]  <= accept && !iss_md;
      twe[1] <= iss_we;
      tld[1] <= iss_load;
      trd[1] <= iss_rd;
      for (int k = 2; k <= DEPTH; k++) begin
        tv[k]  <= tv[k-1] && !flush;
        twe[k] <= twe[k-1];
        tld[k] <= tld[k-1];
        trd[k] <= trd[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      md_rd <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && iss_md) begin
      cnt   <= CW'(MD_CYCLES);
      md_rd <= iss_rd;
    end else if (md_busy) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: scenario tasks feed a scoreboard queue
// of expected {sel_a, sel_b, stall, md_busy, md_done, md_rd}.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       iss_valid;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  logic       iss_use1;
  logic       iss_use2;
  logic [4:0] iss_rd;
  logic       iss_we;
  logic       iss_load;
  logic       iss_md;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;
  logic       md_busy;
  logic       md_done;
  logic [4:0] md_rd;

  int checks = 0;
  int failures = 0;

  logic [11:0] sb [$];
  logic [11:0] got;
  logic [11:0] want;

  typedef struct packed {
    logic       rst;
    logic       fl;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       md;
  } step_t;

  hazard_unit #(
    .DEPTH(2),
    .RW(5),
    .MD_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iss_valid(iss_valid),
    .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2),
    .iss_use1(iss_use1),
    .iss_use2(iss_use2),
    .iss_rd(iss_rd),
    .iss_we(iss_we),
    .iss_load(iss_load),
    .iss_md(iss_md),
    .flush(flush),
    .sel_a(sel_a),
    .sel_b(sel_b),
    .stall(stall),
    .md_busy(md_busy),
    .md_done(md_done),
    .md_rd(md_rd)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic step_t mk(
    bit v, int rs1, int rs2, bit u1, bit u2,
    int rd, bit we, bit ld, bit md,
    bit rst = 1'b0, bit fl = 1'b0);
    step_t s;
    s.rst = rst;
    s.fl  = fl;
    s.v   = v;
    s.rs1 = 5'(rs1);
    s.rs2 = 5'(rs2);
    s.u1  = u1;
    s.u2  = u2;
    s.rd  = 5'(rd);
    s.we  = we;
    s.ld  = ld;
    s.md  = md;
    return s;
  endfunction

  function automatic logic [11:0] ex(
    int sa, int sbv, bit st, bit mb, bit md, int mdrd);
    return {2'(sa), 2'(sbv), st, mb, md, 5'(mdrd)};
  endfunction

  task automatic drive(input step_t s);
    reset     = s.rst;
    flush     = s.fl;
    iss_valid = s.v;
    iss_rs1   = s.rs1;
    iss_rs2   = s.rs2;
    iss_use1  = s.u1;
    iss_use2  = s.u2;
    iss_rd    = s.rd;
    iss_we    = s.we;
    iss_load  = s.ld;
    iss_md    = s.md;
  endtask

  step_t idle;

  task automatic test_reset;
    step_t s [3];
    logic [11:0] e [3];
    s[0] = mk(1, 5, 6, 1, 1, 5, 1, 0, 1, 1, 1); e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = idle;                               e[1] = ex(0, 0, 0, 0, 0, 0);
    s[2] = mk(1, 5, 6, 1, 1, 7, 1, 0, 0);      e[2] = ex(0, 0, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back;
    step_t s [6];
    logic [11:0] e [6];
    s[0] = mk(1, 1, 2, 1, 1, 3, 1, 0, 0); e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 3, 0, 1, 0, 4, 1, 0, 0); e[1] = ex(1, 0, 0, 0, 0, 0);
    s[2] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0); e[2] = ex(0, 0, 0, 0, 0, 0);
    s[3] = mk(1, 1, 2, 1, 1, 6, 1, 0, 0); e[3] = ex(0, 0, 0, 0, 0, 0);
    s[4] = mk(1, 0, 3, 0, 1, 8, 1, 0, 0); e[4] = ex(0, 2, 0, 0, 0, 0);
    s[5] = mk(1, 0, 3, 0, 1, 8, 1, 0, 0); e[5] = ex(0, 0, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_youngest;
    step_t s [4];
    logic [11:0] e [4];
    s[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0);  e[1] = ex(0, 0, 0, 0, 0, 0);
    s[2] = mk(1, 5, 5, 1, 0, 10, 1, 0, 0); e[2] = ex(1, 0, 0, 0, 0, 0);
    s[3] = mk(1, 5, 5, 0, 1, 10, 1, 0, 0); e[3] = ex(0, 2, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL youngest[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use;
    step_t s [7];
    logic [11:0] e [7];
    s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0);   e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 7, 0, 1, 0, 11, 1, 0, 0);  e[1] = ex(1, 0, 1, 0, 0, 0);
    s[2] = mk(1, 7, 0, 1, 0, 11, 1, 0, 0);  e[2] = ex(2, 0, 0, 0, 0, 0);
    s[3] = mk(1, 0, 7, 0, 1, 12, 1, 0, 0);  e[3] = ex(0, 0, 0, 0, 0, 0);
    s[4] = mk(1, 0, 0, 0, 0, 13, 1, 1, 0);  e[4] = ex(0, 0, 0, 0, 0, 0);
    s[5] = mk(1, 1, 13, 1, 1, 14, 1, 0, 0); e[5] = ex(0, 1, 1, 0, 0, 0);
    s[6] = mk(1, 1, 13, 1, 1, 14, 1, 0, 0); e[6] = ex(0, 2, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_r0;
    step_t s [6];
    logic [11:0] e [6];
    s[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 0, 0, 1, 1, 15, 1, 0, 0); e[1] = ex(0, 0, 0, 0, 0, 0);
    s[2] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0);  e[2] = ex(0, 0, 0, 0, 0, 0);
    s[3] = mk(1, 0, 0, 1, 1, 16, 1, 0, 0); e[3] = ex(0, 0, 0, 0, 0, 0);
    s[4] = mk(1, 0, 0, 0, 0, 17, 1, 1, 0); e[4] = ex(0, 0, 0, 0, 0, 0);
    s[5] = mk(0, 17, 0, 1, 0, 0, 0, 0, 0); e[5] = ex(1, 0, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL r0[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_md;
    step_t s [6];
    logic [11:0] e [6];
    s[0] = mk(1, 0, 0, 0, 0, 9, 1, 0, 1);  e[0] = ex(0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 9, 0, 1, 0, 15, 1, 0, 0); e[1] = ex(0, 0, 1, 1, 0, 9);
    s[2] = s[1];                           e[2] = ex(0, 0, 1, 1, 0, 9);
    s[3] = s[1];                           e[3] = ex(0, 0, 1, 1, 0, 9);
    s[4] = s[1];                           e[4] = ex(0, 0, 0, 1, 1, 9);
    s[5] = idle;                           e[5] = ex(0, 0, 0, 0, 0, 9);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL md[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_md_back_to_back;
    step_t s [5];
    logic [11:0] e [5];
    s[0] = mk(1, 0, 0, 0, 0, 20, 1, 0, 1);  e[0] = ex(0, 0, 0, 0, 0, 9);
    s[1] = mk(1, 0, 0, 0, 0, 21, 1, 0, 1);  e[1] = ex(0, 0, 1, 1, 0, 20);
    s[2] = mk(1, 0, 0, 0, 0, 20, 1, 0, 0);  e[2] = ex(0, 0, 1, 1, 0, 20);
    s[3] = mk(1, 20, 0, 0, 0, 22, 1, 0, 0); e[3] = ex(0, 0, 0, 1, 0, 20);
    s[4] = mk(1, 0, 0, 0, 0, 21, 1, 0, 1);  e[4] = ex(0, 0, 0, 1, 1, 20);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL md_b2b[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_flush;
    step_t s [6];
    logic [11:0] e [6];
    s[0] = mk(1, 0, 0, 0, 0, 23, 1, 0, 0);       e[0] = ex(0, 0, 0, 1, 0, 21);
    s[1] = mk(1, 0, 0, 0, 0, 24, 1, 0, 0, 0, 1); e[1] = ex(0, 0, 0, 1, 0, 21);
    s[2] = mk(1, 23, 24, 1, 1, 25, 1, 0, 0);     e[2] = ex(0, 0, 0, 0, 0, 21);
    s[3] = idle;                                 e[3] = ex(0, 0, 0, 0, 0, 21);
    s[4] = idle;                                 e[4] = ex(0, 0, 0, 0, 0, 21);
    s[5] = idle;                                 e[5] = ex(0, 0, 0, 0, 0, 21);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL flush[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_md;
    step_t s [6];
    logic [11:0] e [6];
    s[0] = mk(1, 0, 0, 0, 0, 26, 1, 0, 1);       e[0] = ex(0, 0, 0, 0, 0, 21);
    s[1] = idle;                                 e[1] = ex(0, 0, 0, 1, 0, 26);
    s[2] = mk(1, 0, 0, 0, 0, 27, 1, 0, 0, 1, 0); e[2] = ex(0, 0, 0, 1, 0, 26);
    s[3] = mk(1, 27, 26, 1, 1, 28, 1, 0, 0);     e[3] = ex(0, 0, 0, 0, 0, 0);
    s[4] = idle;                                 e[4] = ex(0, 0, 0, 0, 0, 0);
    s[5] = idle;                                 e[5] = ex(0, 0, 0, 0, 0, 0);
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clock);
      got  = {sel_a, sel_b, stall, md_busy, md_done, md_rd};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rst_md[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_back_to_back();
    test_youngest();
    test_load_use();
    test_r0();
    test_md();
    test_md_back_to_back();
    test_flush();
    test_reset_mid_md();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of downstream writer stages tracked, 1..7. Stage 1 is X/M and stage 2 is M/W.
REQ-002 The block SHALL have parameter RW, default 5, giving the register-address width.
REQ-003 The block SHALL have parameter MD_CYCLES, default 32, giving the multiply/divide latency in cycles, minimum 1.
REQ-004 The block SHALL derive local SW = $clog2(DEPTH+1), the bypass-select width.
REQ-005 The block SHALL use one clock with synchronous, active-high reset. Ports are clock and reset.
REQ-006 The block SHALL have the following ports, one per line:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- iss_valid  in  1  decode-stage instruction present
- iss_rs1  in  RW  source A address
- iss_rs2  in  RW  source B address
- iss_use1, iss_use2  in  1  source A/B is actually read
- iss_rd  in  RW  destination address
- iss_we  in  1  instruction writes iss_rd
- iss_load  in  1  instruction is a load
- iss_md  in  1  instruction is mult/div
- flush  in  1  squash all tracked in-flight state
- sel_a, sel_b  out  SW  bypass source: 0 = register file, k = stage k
- stall  out  1  hold decode, insert bubble
- md_busy  out  1  mult/div in progress
- md_done  out  1  one-cycle pulse, mult/div result ready
- md_rd  out  RW  mult/div destination tag

Function
REQ-007 The block SHALL hold a tracker of DEPTH entries {valid, rd, we, load}, entry 1 youngest.
REQ-008 Each cycle the tracker SHALL shift: entry k+1 takes entry k, and the oldest entry is discarded.
REQ-009 Entry 1 SHALL take the iss_* fields when iss_valid=1 and stall=0 and iss_md=0; otherwise entry 1 SHALL become a bubble (valid=0).
REQ-010 sel_a SHALL be combinational: the smallest k such that entry k has valid=1, we=1, rd==iss_rs1, and rd!=0; otherwise sel_a=0.
REQ-011 sel_a SHALL be 0 whenever iss_use1=0.
REQ-012 sel_b SHALL follow the same rules as REQ-010 and REQ-011 using iss_rs2 and iss_use2.
REQ-013 Register 0 SHALL never be bypassed and SHALL never cause a stall.
REQ-014 Load-use stall: stall SHALL be 1 when entry 1 has valid, we, and load set, and its rd is nonzero and equals a used source.
REQ-015 The load-use stall SHALL last exactly one cycle, after which the matching operand selects stage 2.
REQ-016 An accepted iss_md (iss_valid=1, stall=0) SHALL load the md counter with MD_CYCLES, set md_busy=1, and latch md_rd=iss_rd.
REQ-017 While md_busy=1 the counter SHALL decrement once per cycle.
REQ-018 On the cycle the counter reaches 0, md_done SHALL pulse high for one cycle and md_busy SHALL clear on that same edge.
REQ-019 MD stall: stall SHALL be 1 when md_busy=1 and iss_valid=1 and either:
- iss_md=1, or
- md_rd is nonzero and equals a used source, or
- md_rd is nonzero and equals iss_rd with iss_we=1.
REQ-020 A new iss_md presented in the md_done cycle SHALL be accepted without stall.
REQ-021 When load-use and MD stall conditions coincide, stall SHALL be 1. A single stall output suffices.
REQ-022 stall SHALL be 0 whenever iss_valid=0.
REQ-023 flush=1 SHALL clear all tracker valid bits and clear md_busy and the md counter on the next edge, with no md_done.
REQ-024 flush SHALL take priority over the issue in the same cycle, which is also dropped.
REQ-025 Outputs SHALL have zero latency from the iss_* inputs and one-cycle latency from acceptance to tracker visibility.

Reset
REQ-026 On reset the block SHALL clear all tracker entries to valid=0 and the md counter to 0.
REQ-027 After reset: md_busy=0, md_done=0, md_rd=0, stall=0 (with iss_valid=0), sel_a=sel_b=0.
REQ-028 Reset SHALL take priority over flush and issue.
REQ-029 Reset asserted mid-MD SHALL abort the operation with no md_done.

Verification
REQ-030 Back-to-back ALU ops, DEPTH=2: add r3 accepted, then sub using rs1=r3 -> sel_a=1.
REQ-031 One cycle later, an unrelated op, then an op using rs2=r3 -> sel_b=2. At gap 3 -> sel_b=0.
REQ-032 Both stages hold rd=r5, next op reads r5 -> sel_a=1 (youngest wins).
REQ-033 Load r7 accepted, next op reads r7 -> stall=1 for exactly one cycle, then sel_a=2, stall=0.
REQ-034 Op writes r0, next op reads r0 -> sel_a=0, stall=0.
REQ-035 MD_CYCLES=4: mul r9 accepted at cycle t, op reading r9 waits:
- stall=1 for cycles t+1..t+3,
- md_done=1 at t+4,
- stall=0 at t+4.
REQ-036 Flush or reset at t+2 of an MD operation -> md_busy=0 next cycle, md_done never pulses, all selects 0.
